// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: load/store size encodings, MEM-stage FSM states and byte-lane masks
package mips_mem_pkg;
  localparam logic [1:0] LS_WORD = 2'b00;
  localparam logic [1:0] LS_HALF = 2'b01;
  localparam logic [1:0] LS_BYTE = 2'b10;
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  localparam logic [3:0] LANE_ALL = 4'b1111;
  localparam logic [3:0] LANE_LO  = 4'b0011;
  localparam logic [3:0] LANE_HI  = 4'b1100;
  localparam logic [3:0] LANE_B0  = 4'b0001;
  // reserved size 2'b11 behaves like a word
  function automatic logic misaligned(input logic [1:0] ls, input logic [1:0] off);
    return ls == LS_HALF ? off[0] : ls == LS_BYTE ? 1'b0 : off != 2'b00;
  endfunction
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: store lane/data steering and load lane extract with sign extension
module mem_lane_align
  import mips_mem_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  always_comb begin
    st_be    = st_size == LS_HALF ? (st_off[1] ? LANE_HI : LANE_LO)
             : st_size == LS_BYTE ? LANE_B0 << st_off : LANE_ALL;
    st_wdata = st_size == LS_HALF ? {2{st_data[15:0]}}
             : st_size == LS_BYTE ? {4{st_data[7:0]}} : st_data;
    ld_byte  = 8'(ld_rdata >> {ld_off, 3'b000});
    ld_half  = ld_off[1] ? ld_rdata[31:16] : ld_rdata[15:0];
    ld_data  = ld_size == LS_HALF ? {{16{ld_half[15]}}, ld_half}
             : ld_size == LS_BYTE ? {{24{ld_byte[7]}}, ld_byte} : ld_rdata;
  end
endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM-stage sequencer driving a req/ack data-memory port and stalling the pipeline
module mem_stage_ctrl
  import mips_mem_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [1:0]            LoadStore,
  input  logic [ADDR_WIDTH-1:0] Addr,
  input  logic [31:0]           WriteData,
  output logic                  Stall,
  output logic [31:0]           ReadDataOut,
  output logic                  ReadValid,
  output logic                  AlignError,
  output logic                  BusError,
  output logic                  MemReq,
  output logic                  MemWe,
  output logic [ADDR_WIDTH-1:0] MemAddr,
  output logic [3:0]            MemByteEn,
  output logic [31:0]           MemWData,
  input  logic [31:0]           MemRData,
  input  logic                  MemAck
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    ls_q, off_q;
  logic          ld_q, access, bad;
  logic [3:0]    st_be;
  logic [31:0]   st_wdata, ld_data;
  assign access = MemRead | MemWrite;
  assign bad    = misaligned(LoadStore, Addr[1:0]);
  assign Stall  = state == S_BUSY || (state == S_IDLE && access && !bad);
  mem_lane_align u_align (
    .st_size (LoadStore),
    .st_off  (Addr[1:0]),
    .st_data (WriteData),
    .st_be   (st_be),
    .st_wdata(st_wdata),
    .ld_size (ls_q),
    .ld_off  (off_q),
    .ld_rdata(MemRData),
    .ld_data (ld_data)
  );
  // size/offset are kept so the load extract does not depend on the held EX/MEM inputs
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      ls_q        <= LS_WORD;
      off_q       <= 2'b00;
      ld_q        <= 1'b0;
      ReadDataOut <= '0;
      ReadValid   <= 1'b0;
      AlignError  <= 1'b0;
      BusError    <= 1'b0;
      MemReq      <= 1'b0;
      MemWe       <= 1'b0;
      MemAddr     <= '0;
      MemByteEn   <= '0;
      MemWData    <= '0;
    end else begin
      ReadValid  <= 1'b0;
      AlignError <= 1'b0;
      case (state)
        S_IDLE: if (access) begin
          if (bad) AlignError <= 1'b1;
          else begin
            MemReq    <= 1'b1;
            MemWe     <= MemWrite;
            MemAddr   <= {Addr[ADDR_WIDTH-1:2], 2'b00};
            MemByteEn <= st_be;
            MemWData  <= st_wdata;
            ls_q      <= LoadStore;
            off_q     <= Addr[1:0];
            ld_q      <= !MemWrite;
            cnt       <= '0;
            state     <= S_BUSY;
          end
        end
        S_BUSY: if (MemAck) begin
          MemReq      <= 1'b0;
          ReadDataOut <= ld_data;
          ReadValid   <= ld_q;
          state       <= S_DONE;
        end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          MemReq      <= 1'b0;
          BusError    <= 1'b1;
          ReadDataOut <= '0;
          state       <= S_DONE;
        end else cnt <= cnt + CW'(1);
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: table-driven, hand-sequenced and randomized checks of mem_stage_ctrl
module tb_mem_stage_ctrl;
  logic        Clk = 1'b0, Rst = 1'b1;
  logic        MemRead = 1'b0, MemWrite = 1'b0, MemAck = 1'b0;
  logic [1:0]  LoadStore = 2'b00;
  logic [31:0] Addr = '0, WriteData = '0, MemRData = '0;
  logic        Stall, ReadValid, AlignError, BusError, MemReq, MemWe;
  logic [31:0] ReadDataOut, MemAddr, MemWData;
  logic [3:0]  MemByteEn;
  int total = 0, bad = 0;

  always #5 Clk = ~Clk;

  mem_stage_ctrl #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .Clk(Clk), .Rst(Rst), .MemRead(MemRead), .MemWrite(MemWrite), .LoadStore(LoadStore),
    .Addr(Addr), .WriteData(WriteData), .Stall(Stall), .ReadDataOut(ReadDataOut),
    .ReadValid(ReadValid), .AlignError(AlignError), .BusError(BusError), .MemReq(MemReq),
    .MemWe(MemWe), .MemAddr(MemAddr), .MemByteEn(MemByteEn), .MemWData(MemWData),
    .MemRData(MemRData), .MemAck(MemAck)
  );

  typedef struct {
    logic rd, wr; logic [1:0] ls; logic [31:0] addr, wdata, rdata; int lat;
    int e_stall, e_ae, e_rv; logic [3:0] e_be; logic [31:0] e_maddr, e_wd, e_rdout;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // expectations from the access rules using plain arithmetic
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    int off = int'(v.addr[1:0]);
    int sz = v.ls == 2'd1 ? 2 : v.ls == 2'd2 ? 1 : 4;
    longint x;
    r.e_stall = 0; r.e_ae = 0; r.e_rv = 0; r.e_be = 0; r.e_maddr = 0; r.e_wd = 0; r.e_rdout = 0;
    if (!(v.rd || v.wr)) return r;
    if (off % sz != 0) begin r.e_ae = 1; return r; end
    r.e_stall = v.lat + 1;
    r.e_maddr = v.addr - 32'(off);
    r.e_be    = 4'(((1 << sz) - 1) << off);
    r.e_wd    = sz == 4 ? v.wdata : sz == 2 ? (v.wdata & 32'hFFFF) * 32'h0001_0001
              : (v.wdata & 32'hFF) * 32'h0101_0101;
    if (!v.wr) begin
      r.e_rv = 1;
      x = longint'(v.rdata >> (8 * off)) % (64'd1 << (8 * sz));
      if (sz < 4 && x >= (64'd1 << (8 * sz - 1))) x = x - (64'd1 << (8 * sz));
      r.e_rdout = 32'(x);
    end
    return r;
  endfunction

  // one pipeline access: inputs held while stalled, dropped once the pipeline advances
  task automatic run_access(input vec_t v, input int ncyc, output int n_stall, output int n_req,
                            output int n_rv, output int n_ae, output logic [3:0] be,
                            output logic [31:0] maddr, output logic [31:0] wd, output logic we,
                            output logic [31:0] rdout, output int unstable);
    bit released = 0;
    int age = 0;
    n_stall = 0; n_req = 0; n_rv = 0; n_ae = 0; be = 0; maddr = 0; wd = 0; we = 0; rdout = 0;
    unstable = 0;
    for (int k = 0; k < ncyc; k++) begin
      if (k == 0) begin
        MemRead = v.rd; MemWrite = v.wr; LoadStore = v.ls; Addr = v.addr; WriteData = v.wdata;
      end else if (released) begin
        MemRead = 0; MemWrite = 0;
      end
      MemAck   = MemReq && v.lat > 0 && age == v.lat - 1;
      MemRData = MemAck ? v.rdata : $urandom;
      #1;
      if (Stall) n_stall++; else released = 1;
      if (MemReq) begin
        if (n_req == 0) begin be = MemByteEn; maddr = MemAddr; wd = MemWData; we = MemWe; end
        else if (be !== MemByteEn || maddr !== MemAddr || wd !== MemWData || we !== MemWe) unstable++;
        n_req++; age++;
      end
      if (ReadValid) begin n_rv++; rdout = ReadDataOut; end
      if (AlignError) n_ae++;
      @(posedge Clk); #1;
    end
    MemAck = 0; MemRead = 0; MemWrite = 0;
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    int ns, nq, nr, na, un;
    logic [3:0] be; logic [31:0] ma, wd, rd; logic we;
    run_access(v, v.lat + 5, ns, nq, nr, na, be, ma, wd, we, rd, un);
    chk({tag, " stall"}, 32'(ns), 32'(v.e_stall));
    chk({tag, " align"}, 32'(na), 32'(v.e_ae));
    chk({tag, " reqcyc"}, 32'(nq), v.e_stall != 0 ? 32'(v.lat) : 32'd0);
    chk({tag, " rvalid"}, 32'(nr), 32'(v.e_rv));
    if (v.e_stall != 0) begin
      chk({tag, " byteen"}, 32'(be), 32'(v.e_be));
      chk({tag, " maddr"}, ma, v.e_maddr);
      chk({tag, " wdata"}, wd, v.e_wd);
      chk({tag, " we"}, 32'(we), 32'(v.wr));
      chk({tag, " stable"}, 32'(un), 32'd0);
    end
    if (v.e_rv != 0) chk({tag, " rdata"}, rd, v.e_rdout);
  endtask

  vec_t tbl[12];
  vec_t v;

  initial begin
    int ns, nq, nr, na, un;
    logic [3:0] be; logic [31:0] ma, wd, rd; logic we;
    tbl[0]  = '{0, 1, 2'd0, 32'h100, 32'hDEADBEEF, 32'h0,        1, 2, 0, 0, 4'hF, 32'h100, 32'hDEADBEEF, 32'h0};
    tbl[1]  = '{1, 0, 2'd2, 32'h203, 32'h0,        32'h80FF0000, 3, 4, 0, 1, 4'h8, 32'h200, 32'h0,        32'hFFFFFF80};
    tbl[2]  = '{0, 1, 2'd1, 32'h42,  32'h1234,     32'h0,        1, 2, 0, 0, 4'hC, 32'h40,  32'h12341234, 32'h0};
    tbl[3]  = '{1, 0, 2'd0, 32'h102, 32'h0,        32'h0,        1, 0, 1, 0, 4'h0, 32'h0,   32'h0,        32'h0};
    tbl[4]  = '{1, 0, 2'd1, 32'h106, 32'h0,        32'h80017FFF, 2, 3, 0, 1, 4'hC, 32'h104, 32'h0,        32'hFFFF8001};
    tbl[5]  = '{1, 0, 2'd2, 32'h301, 32'h0,        32'h12345678, 1, 2, 0, 1, 4'h2, 32'h300, 32'h0,        32'h56};
    tbl[6]  = '{0, 1, 2'd2, 32'h13,  32'hAB,       32'h0,        1, 2, 0, 0, 4'h8, 32'h10,  32'hABABABAB, 32'h0};
    tbl[7]  = '{1, 0, 2'd3, 32'h202, 32'h0,        32'h0,        1, 0, 1, 0, 4'h0, 32'h0,   32'h0,        32'h0};
    tbl[8]  = '{1, 1, 2'd0, 32'h500, 32'h11223344, 32'h0,        1, 2, 0, 0, 4'hF, 32'h500, 32'h11223344, 32'h0};
    tbl[9]  = '{1, 0, 2'd1, 32'h101, 32'h0,        32'h0,        1, 0, 1, 0, 4'h0, 32'h0,   32'h0,        32'h0};
    tbl[10] = '{0, 0, 2'd0, 32'h0,   32'h0,        32'h0,        1, 0, 0, 0, 4'h0, 32'h0,   32'h0,        32'h0};
    tbl[11] = '{1, 0, 2'd0, 32'h400, 32'h0,        32'hCAFEF00D, 2, 3, 0, 1, 4'hF, 32'h400, 32'h0,        32'hCAFEF00D};
    repeat (3) @(posedge Clk);
    #1 Rst = 0;
    #1;
    chk("rst stall", 32'(Stall), 0);
    chk("rst req", 32'(MemReq), 0);
    chk("rst flags", {29'd0, ReadValid, AlignError, BusError}, 0);
    chk("rst we/be", {27'd0, MemWe, MemByteEn}, 0);
    chk("rst maddr", MemAddr, 0);
    chk("rst wdata", MemWData, 0);
    chk("rst rdout", ReadDataOut, 0);
    @(posedge Clk); #1;
    for (int i = 0; i < 12; i++) apply_vec(tbl[i], $sformatf("vec%0d", i));

    // no ack at all: abort after the timeout, error stays set, next access still works
    v = '{1, 0, 2'd0, 32'h300, 32'h0, 32'h0, 0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 32'h0};
    run_access(v, 24, ns, nq, nr, na, be, ma, wd, we, rd, un);
    chk("tmo reqcyc", 32'(nq), 16);
    chk("tmo stall", 32'(ns), 17);
    chk("tmo rvalid", 32'(nr), 0);
    chk("tmo buserr", 32'(BusError), 1);
    chk("tmo rdout", ReadDataOut, 0);
    chk("tmo req low", 32'(MemReq), 0);
    apply_vec(model('{1, 0, 2'd0, 32'h404, 32'h0, 32'h5, 1, 0, 0, 0, 4'h0, 32'h0, 32'h0, 32'h0}), "post_tmo");
    chk("tmo sticky", 32'(BusError), 1);

    for (int i = 0; i < 40; i++) begin
      v.rd = 1'($urandom); v.wr = 1'($urandom); v.ls = 2'($urandom);
      v.addr = $urandom; v.wdata = $urandom; v.rdata = $urandom; v.lat = int'($urandom_range(1, 4));
      apply_vec(model(v), $sformatf("rnd%0d", i));
    end

    // reset while BUSY, then a late ack that must be ignored
    MemRead = 1; LoadStore = 2'd0; Addr = 32'h80;
    #1 chk("rb stall0", 32'(Stall), 1);
    @(posedge Clk); #1;
    chk("rb req", 32'(MemReq), 1);
    Rst = 1;
    @(posedge Clk); #1;
    Rst = 0; MemRead = 0; MemAck = 1; MemRData = 32'h1234_5678;
    #1;
    chk("rb req drop", 32'(MemReq), 0);
    chk("rb stall", 32'(Stall), 0);
    chk("rb buserr", 32'(BusError), 0);
    @(posedge Clk); #1;
    MemAck = 0;
    chk("rb rvalid", 32'(ReadValid), 0);
    chk("rb req idle", 32'(MemReq), 0);
    @(posedge Clk); #1;
    chk("rb rvalid2", 32'(ReadValid), 0);
    apply_vec(model('{1, 0, 2'd1, 32'h82, 32'h0, 32'h7FFF_0000, 1, 0, 0, 0, 4'h0, 32'h0, 32'h0, 32'h0}), "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
